// File: rtl/db_ram_1p_ctrl.sv
// Initiator-side controller for a single-port RAM: arbitrates read and write
// request channels, returns read data two cycles after ack, and zero-fills the array on command.
module db_ram_1p_ctrl #(
    parameter int Word_Width = 128,
    parameter int Addr_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
    input  logic                  wr_req_i,
    input  logic [Addr_Width-1:0] wr_addr_i,
    input  logic [Word_Width-1:0] wr_data_i,
    output logic                  wr_ack_o,
    input  logic                  rd_req_i,
    input  logic [Addr_Width-1:0] rd_addr_i,
    output logic                  rd_ack_o,
    output logic                  rd_valid_o,
    output logic [Word_Width-1:0] rd_data_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [Addr_Width-1:0] ram_addr_o,
    output logic [Word_Width-1:0] ram_data_o,
    input  logic [Word_Width-1:0] ram_data_i
);

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    localparam logic [Addr_Width-1:0] last_addr = '1;
    localparam logic [Addr_Width-1:0] cnt_one   = {{(Addr_Width-1){1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [Addr_Width-1:0] clr_cnt_reg, clr_cnt_next;
    logic                  last_wr_reg, last_wr_next;   // 1: most recent grant was a write
    logic                  clr_done_reg, clr_done_next;
    logic                  rd_pend_reg;
    logic                  rd_valid_reg;
    logic [Word_Width-1:0] rd_data_reg;
    logic                  grant_wr;
    logic                  grant_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clr_cnt_reg  <= '0;
            last_wr_reg  <= 1'b0;
            clr_done_reg <= 1'b0;
            rd_pend_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            last_wr_reg  <= last_wr_next;
            clr_done_reg <= clr_done_next;
            // RAM output is valid the cycle after issue; capture it then.
            rd_pend_reg  <= grant_rd;
            rd_valid_reg <= rd_pend_reg;
            if (rd_pend_reg) begin
                rd_data_reg <= ram_data_i;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        last_wr_next  = last_wr_reg;
        clr_done_next = 1'b0;
        grant_wr      = 1'b0;
        grant_rd      = 1'b0;
        ram_cen_o     = 1'b1;
        ram_wen_o     = 1'b1;
        ram_addr_o    = '0;
        ram_data_o    = '0;

        case (state_reg)
            IDLE: begin
                if (clr_start_i) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end else begin
                    if (wr_req_i && rd_req_i) begin
                        grant_wr = !last_wr_reg;
                        grant_rd = last_wr_reg;
                    end else begin
                        grant_wr = wr_req_i;
                        grant_rd = rd_req_i;
                    end

                    if (grant_wr) begin
                        last_wr_next = 1'b1;
                        ram_cen_o    = 1'b0;
                        ram_wen_o    = 1'b0;
                        ram_addr_o   = wr_addr_i;
                        ram_data_o   = wr_data_i;
                    end else if (grant_rd) begin
                        last_wr_next = 1'b0;
                        ram_cen_o    = 1'b0;
                        ram_addr_o   = rd_addr_i;
                    end
                end
            end

            CLEAR: begin
                ram_cen_o    = 1'b0;
                ram_wen_o    = 1'b0;
                ram_addr_o   = clr_cnt_reg;
                clr_cnt_next = clr_cnt_reg + cnt_one;
                if (clr_cnt_reg == last_addr) begin
                    state_next    = IDLE;
                    clr_done_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_oen_o  = 1'b0;
    assign wr_ack_o   = grant_wr;
    assign rd_ack_o   = grant_rd;
    assign clr_busy_o = (state_reg == CLEAR);
    assign clr_done_o = clr_done_reg;
    assign rd_valid_o = rd_valid_reg;
    assign rd_data_o  = rd_data_reg;

endmodule

// File: doc/db_ram_1p_ctrl.md
Name: db_ram_1p_ctrl

Overview:
Initiator-side controller for one single-port RAM instance with active-low cen/wen/oen.
- Accepts independent write and read request channels (req/ack).
- Arbitrates between them and drives the RAM control, address and data pins.
- Returns read data with fixed latency.
- Includes a bulk-clear engine that zero-fills the whole array on command.
- Sits between deblocking-filter datapath logic and its line/pixel buffers.

Parameters:
Word_Width  128  RAM word width in bits
Addr_Width  8    RAM address width; depth = 1<<Addr_Width

Ports:
clk          input   1           clock, all state on rising edge
rst_n        input   1           asynchronous reset, active low
clr_start_i  input   1           pulse: start zero-fill of entire RAM
clr_busy_o   output  1           high while zero-fill in progress
clr_done_o   output  1           one-cycle pulse after last clear write
wr_req_i     input   1           write request, held until wr_ack_o
wr_addr_i    input   Addr_Width  write address
wr_data_i    input   Word_Width  write data
wr_ack_o     output  1           write issued this cycle
rd_req_i     input   1           read request, held until rd_ack_o
rd_addr_i    input   Addr_Width  read address
rd_ack_o     output  1           read issued this cycle
rd_valid_o   output  1           rd_data_o valid, one-cycle pulse
rd_data_o    output  Word_Width  read data, held until next rd_valid_o
ram_cen_o    output  1           RAM chip enable, low active
ram_oen_o    output  1           RAM output enable, low active
ram_wen_o    output  1           RAM write enable, low active
ram_addr_o   output  Addr_Width  RAM address
ram_data_o   output  Word_Width  RAM write data
ram_data_i   input   Word_Width  RAM read data

Behaviour:
- Reset values: FSM=IDLE; clr_busy_o=0; clr_done_o=0; rd_valid_o=0; rd_data_o=0; last-grant=READ. With no grant, RAM pins idle: cen=1, wen=1, addr=0, data=0. ram_oen_o is constant 0.
- RAM pin timing: RAM pins are combinational from FSM state and the current grant. The RAM samples them at the end of issue cycle T.
- Handshake: wr_ack_o/rd_ack_o are combinational and asserted in cycle T when that request is granted. The requester may change address/data in T+1. At most one ack per cycle.
- Write issue: cen=0, wen=0, addr=wr_addr_i, data=wr_data_i.
- Read issue: cen=0, wen=1, addr=rd_addr_i.
- Read return: RAM output is valid during T+1. It is registered into rd_data_o at the end of T+1. rd_valid_o=1 during T+2. Latency is 2 cycles from ack to valid.
- Back-to-back: reads may be issued every cycle. rd_valid_o then stays high with new data each cycle.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the type opposite to last-grant (round-robin), then update last-grant.
  - A lone grant also updates last-grant.
- Read-after-write to the same address in consecutive grants returns the new data, because the RAM write completes at the end of T.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR when clr_start_i=1. This takes precedence over pending requests in that cycle; no ack is given.
  - CLEAR: clear counter starts at 0. Each cycle: cen=0, wen=0, addr=counter, data=0. Counter increments.
  - When counter = (1<<Addr_Width)-1 is written, go to IDLE and pulse clr_done_o in the following cycle (first IDLE cycle).
  - clr_busy_o=1 in every CLEAR cycle.
  - No acks in CLEAR; requests stay pending. clr_start_i is ignored in CLEAR.
  - Reads already in flight when CLEAR begins still complete with their 2-cycle rd_valid_o.
- Counter: Addr_Width bits. It wraps naturally to 0 after the last address; the wrap is not observable.
- Reset mid-operation (clear or in-flight read): everything returns to reset values immediately. The pending rd_valid_o is dropped. Partial clear is not resumed.

Test Plan:
- Reset, then write addr 0x05 data 0xA5..A5; read 0x05 -> wr_ack_o in T; rd_ack_o in T'; rd_valid_o at T'+2 with 0xA5..A5.
- wr_req and rd_req both held from reset (last-grant=READ) -> grants alternate W,R,W,R; ack never asserted for both in one cycle.
- Reads 0x10,0x11,0x12 in consecutive cycles (preloaded 1,2,3) -> rd_valid_o high 3 consecutive cycles, data 1,2,3.
- Write 0x20=7 then read 0x20 next cycle -> returned 7.
- Fill 0x00..0xFF nonzero; pulse clr_start_i -> clr_busy_o high 256 cycles, clr_done_o pulse once; reads of 0x00, 0x7F, 0xFF return 0; a request held during clear is acked the cycle after busy drops.
- Assert rst_n=0 at clear count 0x40 -> clr_busy_o=0 and cen=1 at once; after release, no clr_done_o and no spurious rd_valid_o.
